// File: rtl/mul_div_unit_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   mdu_op_e    - operation select driven by the core (MULT/MULTU/DIV/DIVU)
//   mdu_state_e - sequencer states (IDLE, CALC, SIGN)
//   is_div      - op selects a divide
//   is_signed   - op treats its operands as two's complement
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op[1];
  endfunction

  function automatic logic is_signed(input mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: core <-> multiply/divide unit connection.
//   start/op/a/b  - operation issue (sampled by the unit only in IDLE)
//   hi_we/lo_we   - MTHI/MTLO strobes, wdata is the value written
//   busy/done     - operation in progress / one-cycle completion pulse
//   hi/lo         - architectural HI/LO registers
// master: core side, slave: the unit.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);

  logic                 start;
  mdu_pkg::mdu_op_e     op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 hi_we;
  logic                 lo_we;
  logic [WIDTH-1:0]     wdata;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     hi;
  logic [WIDTH-1:0]     lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO pair.
// One result bit per cycle; latency WIDTH+2 cycles from the start edge to done.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset (aborts any operation, clears HI/LO)
//   bus  - mul_div_unit_if.slave: start/op/a/b issue, hi_we/lo_we/wdata writes,
//          busy/done status, hi/lo registers (all outputs come from flops)
// Operands are reduced to magnitudes at issue, the unsigned core runs for
// WIDTH cycles, and the SIGN cycle restores result signs and writes HI/LO.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mul_div_unit_if.slave bus
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  // Absolute value for signed ops; unsigned ops pass through untouched.
  // The most-negative value maps onto itself, which is the correct unsigned
  // magnitude 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                    use_sign);
    logic [WIDTH-1:0] r;
    if (use_sign && (v < 0)) r = -v;
    else                     r = v;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // control state
  mdu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              load;
  logic              step;
  logic              finish;

  // datapath state (no reset: only meaningful between load and finish)
  mdu_op_e             op_q;
  logic [2*WIDTH-1:0]  acc_q;
  logic [WIDTH-1:0]    opnd_q;
  logic                neg_q;
  logic                neg_rem_q;
  logic                div0_q;

  // issue-time operand conditioning
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    sgn_op;
  logic                    sa;
  logic                    sb;
  logic [WIDTH-1:0]        mag_a;
  logic [WIDTH-1:0]        mag_b;

  assign a_s    = bus.a;
  assign b_s    = bus.b;
  assign sgn_op = is_signed(bus.op);
  assign sa     = sgn_op && (a_s < 0);
  assign sb     = sgn_op && (b_s < 0);
  assign mag_a  = magnitude(a_s, sgn_op);
  assign mag_b  = magnitude(b_s, sgn_op);

  // One multiply iteration: acc = {partial product, remaining multiplier bits}.
  // When the multiplier LSB is set, add the multiplicand into the upper half,
  // then shift the whole accumulator right, keeping the carry.
  logic [WIDTH:0]      mul_sum;
  logic [2*WIDTH-1:0]  acc_mul;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign acc_mul = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

  // One restoring-divide iteration: acc = {remainder, dividend/quotient}.
  // The partial remainder is the WIDTH+1-bit window after shifting in the next
  // dividend bit; a non-negative trial subtraction sets the quotient bit.
  logic [WIDTH:0]      div_shift;
  logic [WIDTH+1:0]    div_diff;
  logic [2*WIDTH-1:0]  acc_div;

  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  assign acc_div   = div_diff[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Sign restoration. A zero divisor forces the quotient to all ones; the
  // remainder path already yields the original dividend in that case.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign prod   = cneg_2w(acc_q, neg_q);
  assign quo    = div0_q ? {WIDTH{1'b1}} : cneg_w(acc_q[WIDTH-1:0], neg_q);
  assign rem    = cneg_w(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
  assign res_hi = is_div(op_q) ? rem : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div(op_q) ? quo : prod[WIDTH-1:0];

  // sequencer next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          cnt_d   = '0;
          load    = 1'b1;
        end
      end
      CALC: begin
        step  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = SIGN;
      end
      SIGN: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // HI/LO next value: result at SIGN exit, MTHI/MTLO only in IDLE without start
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (finish) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else if ((state_q == IDLE) && !bus.start) begin
      if (bus.hi_we) hi_d = bus.wdata;
      if (bus.lo_we) lo_d = bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= finish;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      op_q      <= bus.op;
      neg_q     <= sa ^ sb;
      neg_rem_q <= sa;
      div0_q    <= (bus.b == '0);
      if (is_div(bus.op)) begin
        acc_q  <= {{WIDTH{1'b0}}, mag_a};
        opnd_q <= mag_b;
      end else begin
        acc_q  <= {{WIDTH{1'b0}}, mag_b};
        opnd_q <= mag_a;
      end
    end else if (step) begin
      acc_q <= is_div(op_q) ? acc_div : acc_mul;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed testbench for mul_div_unit at WIDTH=32.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mul_div_unit_if #(.WIDTH(32)) bus();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Presents an operation for exactly one rising edge (caller is at a negedge).
  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Cycle n is the interval after rising edge n-1 (start sampled at edge 0).
  // Returns the cycle in which done is seen (capped at 200) and busy count.
  task automatic wait_done(input int start_cyc, output int cyc, output int busy_cnt);
    cyc      = start_cyc;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && cyc < 200) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h expected 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h expected 00000000", bus.lo); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL post_reset_idle: busy=%b done=%b expected 0/0", bus.busy, bus.done); end
  endtask

  task automatic test_multu();
    int cyc, bc;
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, cyc, bc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL multu_latency: done in cycle %0d expected 34", cyc); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles: busy for %0d cycles expected 33", bc); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL multu_busy_with_done: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", bus.lo); end
    @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b expected 0", bus.done); end
  endtask

  task automatic test_mult();
    int cyc, bc;
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_done(1, cyc, bc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL mult_latency: done in cycle %0d expected 34", cyc); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h expected fffffff1", bus.lo); end
  endtask

  task automatic test_div_signed();
    int cyc, bc;
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, cyc, bc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL div_latency: done in cycle %0d expected 34", cyc); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", bus.hi); end
  endtask

  task automatic test_divu();
    int cyc, bc;
    issue(MDU_DIVU, 32'd7, 32'd2);
    wait_done(1, cyc, bc);
    checks++; if (bus.lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h expected 00000003", bus.lo); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h expected 00000001", bus.hi); end
    // unsigned treatment of a large dividend: 0xFFFFFFF9 / 2 = 0x7FFFFFFC r 1
    @(negedge clk);
    issue(MDU_DIVU, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, cyc, bc);
    checks++; if (bus.lo !== 32'h7FFF_FFFC) begin errors++; $display("FAIL divu_big_lo: got %h expected 7ffffffc", bus.lo); end
    checks++; if (bus.hi !== 32'd1) begin errors++; $display("FAIL divu_big_hi: got %h expected 00000001", bus.hi); end
  endtask

  task automatic test_div_zero();
    int cyc, bc;
    issue(MDU_DIV, 32'h1234_5678, 32'd0);
    wait_done(1, cyc, bc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL div0_latency: done in cycle %0d expected 34", cyc); end
    checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("FAIL div0_hi: got %h expected 12345678", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffffff", bus.lo); end
    // negative dividend: hi must still be the original dividend
    @(negedge clk);
    issue(MDU_DIV, 32'hFFFF_FFF0, 32'd0);
    wait_done(1, cyc, bc);
    checks++; if (bus.hi !== 32'hFFFF_FFF0) begin errors++; $display("FAIL div0_neg_hi: got %h expected fffffff0", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_neg_lo: got %h expected ffffffff", bus.lo); end
  endtask

  task automatic test_div_overflow();
    int cyc, bc;
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, cyc, bc);
    checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL divovf_lo: got %h expected 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL divovf_hi: got %h expected 00000000", bus.hi); end
  endtask

  task automatic test_mthi();
    // lo is 0x80000000 from the overflow case
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.hi_we = 1'b0;
    checks++; if (bus.hi !== 32'hCAFE_F00D) begin errors++; $display("FAIL mthi_hi: got %h expected cafef00d", bus.hi); end
    checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL mthi_lo_kept: got %h expected 80000000", bus.lo); end
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0BAD_BEEF;
    @(negedge clk);
    bus.lo_we = 1'b0;
    checks++; if (bus.lo !== 32'h0BAD_BEEF) begin errors++; $display("FAIL mtlo_lo: got %h expected 0badbeef", bus.lo); end
    checks++; if (bus.hi !== 32'hCAFE_F00D) begin errors++; $display("FAIL mtlo_hi_kept: got %h expected cafef00d", bus.hi); end
  endtask

  task automatic test_write_while_busy();
    int cyc, bc;
    issue(MDU_DIVU, 32'd100, 32'd7);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1111_1111;
    repeat (8) @(negedge clk);
    checks++; if (bus.hi !== 32'hCAFE_F00D) begin errors++; $display("FAIL busy_write_hi: got %h expected cafef00d", bus.hi); end
    checks++; if (bus.lo !== 32'h0BAD_BEEF) begin errors++; $display("FAIL busy_write_lo: got %h expected 0badbeef", bus.lo); end
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    wait_done(9, cyc, bc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL busy_write_latency: done in cycle %0d expected 34", cyc); end
    checks++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin errors++; $display("FAIL busy_write_result: got hi=%h lo=%h expected hi=00000002 lo=0000000e", bus.hi, bus.lo); end
  endtask

  task automatic test_start_with_lo_we();
    int cyc, bc;
    @(negedge clk);
    bus.lo_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    issue(MDU_MULTU, 32'd6, 32'd7);
    bus.lo_we = 1'b0;
    checks++; if (bus.lo !== 32'd14) begin errors++; $display("FAIL start_lo_we_dropped: got %h expected 0000000e", bus.lo); end
    wait_done(1, cyc, bc);
    checks++; if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin errors++; $display("FAIL start_lo_we_result: got hi=%h lo=%h expected hi=00000000 lo=0000002a", bus.hi, bus.lo); end
  endtask

  task automatic test_ignored_start();
    int dones;
    logic [31:0] hi_s, lo_s;
    dones = 0;
    hi_s  = '0;
    lo_s  = '0;
    @(negedge clk);
    issue(MDU_DIVU, 32'd7, 32'd2);
    repeat (4) @(negedge clk);
    issue(MDU_MULTU, 32'd3, 32'd3);
    for (int i = 0; i < 60; i++) begin
      if (bus.done === 1'b1) begin
        dones++;
        hi_s = bus.hi;
        lo_s = bus.lo;
      end
      @(negedge clk);
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignored_start_dones: got %0d done pulses expected 1", dones); end
    checks++; if (hi_s !== 32'd1 || lo_s !== 32'd3) begin errors++; $display("FAIL ignored_start_result: got hi=%h lo=%h expected hi=00000001 lo=00000003", hi_s, lo_s); end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    issue(MDU_MULT, 32'h7FFF_FFFF, 32'd2);
    wait_done(1, cyc, bc);
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_first: got hi=%h lo=%h expected hi=00000000 lo=fffffffe", bus.hi, bus.lo); end
    // issue the next op in the done cycle
    issue(MDU_DIV, 32'hFFFF_FF9C, 32'd7);
    wait_done(1, cyc, bc);
    checks++; if (cyc !== 34) begin errors++; $display("FAIL b2b_latency: done in cycle %0d expected 34", cyc); end
    checks++; if (bus.lo !== 32'hFFFF_FFF2 || bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_second: got hi=%h lo=%h expected hi=fffffffe lo=fffffff2", bus.hi, bus.lo); end
  endtask

  task automatic test_reset_abort();
    int dones;
    dones = 0;
    @(negedge clk);
    issue(MDU_MULT, 32'd1000, 32'd1000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL abort_hilo: got hi=%h lo=%h expected 0/0", bus.hi, bus.lo); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 45; i++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses expected 0", dones); end
    checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin errors++; $display("FAIL abort_idle: busy=%b hi=%h lo=%h expected 0/0/0", bus.busy, bus.hi, bus.lo); end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = MDU_MULT;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    test_reset();
    test_multu();
    test_mult();
    test_div_signed();
    test_divu();
    test_div_zero();
    test_div_overflow();
    test_mthi();
    test_write_while_busy();
    test_start_with_lo_we();
    test_ignored_start();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
